pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 d_srcA, d_srcB  in  regid_t each  D-stage source register ids.
REQ-004 d_useA, d_useB  in  1 each  D-stage source actually read.
REQ-005 e_dstM, m_dstM  in  regid_t each  load destinations in E and M (R0 = none).
REQ-006 d_br_taken  in  1  D-stage branch/jump resolved taken this cycle.
REQ-007 d_br_target  in  word_t  redirect address, valid with d_br_taken.
REQ-008 imem_busy, dmem_busy  in  1 each  instruction/data memory not ready.
REQ-009 m_stat_bad  in  1  M-stage status is not STAT_AOK.
REQ-010 f_stall, d_stall, e_stall, m_stall  out  1 each  hold that stage's pipeline register.
REQ-011 d_bubble, e_bubble, w_bubble  out  1 each  load a NOP into that stage's pipeline register.
REQ-012 redir_valid  out  1  fetch shall take redir_pc as next PC.
REQ-013 redir_pc  out  word_t  redirect address.
REQ-014 halted  out  1  CPU stopped.
REQ-015 stall_cycles  out  32  count of cycles with f_stall=1.

Function
REQ-016 FSM states RUN, IWAIT, DWAIT, HALT; priority HALT > DWAIT > IWAIT > load-use > RUN.
REQ-017 m_stat_bad=1 in any state -> HALT next cycle; HALT is left only by reset.
REQ-018 HALT: all *_stall=1, all *_bubble=0, redir_valid=0, halted=1.
REQ-019 dmem_busy=1 (not halting) -> DWAIT; DWAIT: f/d/e/m_stall=1, w_bubble=1; leave when dmem_busy=0.
REQ-020 imem_busy=1, dmem_busy=0 -> IWAIT; IWAIT: f_stall=1, d_bubble=1, E/M/W advance; leave when imem_busy=0.
REQ-021 Load-use: (d_useA & d_srcA==e_dstM) or (d_useA & d_srcA==m_dstM), same for B, with source != R0 -> f_stall=d_stall=1, e_bubble=1.
REQ-022 Load-use is a pure function of current inputs; a load in E produces two consecutive stall cycles (E then M match).
REQ-023 d_br_taken while f_stall=0 -> redir_valid=1, redir_pc=d_br_target in the same cycle (combinational).
REQ-024 d_br_taken while f_stall=1 and no redirect already pending -> latch target into pend_pc, set pend=1; the redirect is not lost.
REQ-025 pend=1 and f_stall=0 -> redir_valid=1, redir_pc=pend_pc; pend clears on that edge.
REQ-026 d_br_taken while pend=1 -> ignored (D stalled, same branch re-presented).
REQ-027 d_br_taken while d_stall=1 -> no latch, no redirect (operands not final).
REQ-028 stall_cycles increments by 1 each cycle f_stall=1, except in HALT; wraps 0xFFFF_FFFF -> 0.
REQ-029 dmem_busy and imem_busy both 1 -> DWAIT behaviour; IWAIT entered afterwards if imem still busy.

Reset
REQ-030 resetn=0 at edge -> state RUN, pend=0, pend_pc=0, stall_cycles=0.
REQ-031 Outputs during and right after reset: all stalls/bubbles 0, redir_valid=0, halted=0.
REQ-032 Reset mid-DWAIT/IWAIT/HALT discards the pending redirect; no output glitch beyond REQ-031.

Structure
REQ-033 regid_t, word_t, R0, STAT_* in the shared defs package; FSM state enum local to pipe_ctrl.
REQ-034 One sub-module, pipe_hazard_det (combinational load-use compare, REQ-021/022); everything else in pipe_ctrl.

Verification
REQ-035 d_srcA=5, d_useA=1, e_dstM=5 -> f/d_stall=1, e_bubble=1; next cycle m_dstM=5 -> stall again; third cycle none.
REQ-036 d_srcB=0, d_useB=1, e_dstM=0 -> no stall.
REQ-037 imem_busy=1 for 3 cycles, d_br_taken=1 target 0xBFC0_0100 in cycle 1 -> redir_valid=0 during wait, redir_valid=1 redir_pc=0xBFC0_0100 on cycle 4, stall_cycles=3.
REQ-038 dmem_busy=1 with imem_busy=1 for 2 cycles, then dmem_busy=0 -> DWAIT 2 cycles (w_bubble=1), then IWAIT.
REQ-039 m_stat_bad=1 -> halted=1 next cycle, all stalls=1, stall_cycles frozen; resetn=0 -> RUN, counters 0.
REQ-040 stall_cycles preloaded 0xFFFF_FFFF via forced stall -> one more stall cycle reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
// Register ids, data words, status codes and the load-use compare helper.
package pipe_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regid_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam regid_t R0 = '0;

    typedef enum logic [1:0] {
        STAT_AOK,
        STAT_HLT,
        STAT_ADR,
        STAT_INS
    } stat_e;

    function automatic logic src_hit(
        input regid_t src,
        input logic   used,
        input regid_t e_dst,
        input regid_t m_dst
    );
        return used && (src != R0) && ((src == e_dst) || (src == m_dst));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_ctrl.
// slave is the controller's view, master the datapath's view.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    regid_t      d_srcA;
    regid_t      d_srcB;
    logic        d_useA;
    logic        d_useB;
    regid_t      e_dstM;
    regid_t      m_dstM;
    logic        d_br_taken;
    word_t       d_br_target;
    logic        imem_busy;
    logic        dmem_busy;
    logic        m_stat_bad;
    logic        f_stall;
    logic        d_stall;
    logic        e_stall;
    logic        m_stall;
    logic        d_bubble;
    logic        e_bubble;
    logic        w_bubble;
    logic        redir_valid;
    word_t       redir_pc;
    logic        halted;
    logic [31:0] stall_cycles;

    modport slave (
        input  d_srcA, d_srcB, d_useA, d_useB, e_dstM, m_dstM,
        input  d_br_taken, d_br_target, imem_busy, dmem_busy, m_stat_bad,
        output f_stall, d_stall, e_stall, m_stall,
        output d_bubble, e_bubble, w_bubble,
        output redir_valid, redir_pc, halted, stall_cycles
    );

    modport master (
        output d_srcA, d_srcB, d_useA, d_useB, e_dstM, m_dstM,
        output d_br_taken, d_br_target, imem_busy, dmem_busy, m_stat_bad,
        input  f_stall, d_stall, e_stall, m_stall,
        input  d_bubble, e_bubble, w_bubble,
        input  redir_valid, redir_pc, halted, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detect: D-stage sources against load destinations in E/M.
// Purely combinational, so a load in E stalls twice (E match, then M match).
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  regid_t i_srcA,
    input  regid_t i_srcB,
    input  logic   i_useA,
    input  logic   i_useB,
    input  regid_t i_e_dstM,
    input  regid_t i_m_dstM,
    output logic   o_load_use
);

    logic w_hitA;
    logic w_hitB;

    assign w_hitA     = src_hit(i_srcA, i_useA, i_e_dstM, i_m_dstM);
    assign w_hitB     = src_hit(i_srcB, i_useB, i_e_dstM, i_m_dstM);
    assign o_load_use = w_hitA | w_hitB;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/redirect controller with halt FSM and stall counter.
// Modes are resolved from the current inputs; only HALT is sticky state.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {RUN, IWAIT, DWAIT, HALT} state_e;

    state_e      r_state;
    state_e      w_next;
    state_e      w_mode;
    logic        r_pend;
    word_t       r_pend_pc;
    logic [31:0] r_stall_cycles;

    logic        w_lu;
    logic        w_f_stall;
    logic        w_d_stall;
    logic        w_e_stall;
    logic        w_m_stall;
    logic        w_d_bubble;
    logic        w_e_bubble;
    logic        w_w_bubble;
    logic        w_halted;
    logic        w_redir_valid;
    word_t       w_redir_pc;
    logic        w_latch;

    pipe_hazard_det u_haz (
        .i_srcA     (bus.d_srcA),
        .i_srcB     (bus.d_srcB),
        .i_useA     (bus.d_useA),
        .i_useB     (bus.d_useB),
        .i_e_dstM   (bus.e_dstM),
        .i_m_dstM   (bus.m_dstM),
        .o_load_use (w_lu)
    );

    always_comb begin
        w_mode     = RUN;
        w_next     = RUN;
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_e_stall  = 1'b0;
        w_m_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_w_bubble = 1'b0;
        w_halted   = 1'b0;

        if (r_state == HALT)    w_mode = HALT;
        else if (bus.dmem_busy) w_mode = DWAIT;
        else if (bus.imem_busy) w_mode = IWAIT;
        else                    w_mode = RUN;

        w_next = (r_state == HALT || bus.m_stat_bad) ? HALT : w_mode;

        unique case (w_mode)
            HALT: begin
                w_f_stall = 1'b1;
                w_d_stall = 1'b1;
                w_e_stall = 1'b1;
                w_m_stall = 1'b1;
                w_halted  = 1'b1;
            end
            DWAIT: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_e_stall  = 1'b1;
                w_m_stall  = 1'b1;
                w_w_bubble = 1'b1;
            end
            IWAIT: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
            end
            RUN: begin
                w_f_stall  = w_lu;
                w_d_stall  = w_lu;
                w_e_bubble = w_lu;
            end
        endcase

        // Reset masks every control so the datapath never sees a stray hold.
        if (!resetn) begin
            w_f_stall  = 1'b0;
            w_d_stall  = 1'b0;
            w_e_stall  = 1'b0;
            w_m_stall  = 1'b0;
            w_d_bubble = 1'b0;
            w_e_bubble = 1'b0;
            w_w_bubble = 1'b0;
            w_halted   = 1'b0;
        end
    end

    assign w_redir_valid = resetn && !w_f_stall && (r_pend || bus.d_br_taken);
    assign w_redir_pc    = r_pend ? r_pend_pc : bus.d_br_target;
    assign w_latch       = bus.d_br_taken && w_f_stall && !w_d_stall && !r_pend;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= RUN;
            r_pend         <= 1'b0;
            r_pend_pc      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_pend    <= 1'b1;
                r_pend_pc <= bus.d_br_target;
            end else if (r_pend && !w_f_stall) begin
                r_pend <= 1'b0;
            end
            if (w_f_stall && w_mode != HALT)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.f_stall      = w_f_stall;
    assign bus.d_stall      = w_d_stall;
    assign bus.e_stall      = w_e_stall;
    assign bus.m_stall      = w_m_stall;
    assign bus.d_bubble     = w_d_bubble;
    assign bus.e_bubble     = w_e_bubble;
    assign bus.w_bubble     = w_w_bubble;
    assign bus.redir_valid  = w_redir_valid;
    assign bus.redir_pc     = w_redir_pc;
    assign bus.halted       = w_halted;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected controls queued per step, checked mid-cycle.
// Flag order: f,d,e,m stall / d,e,w bubble / redir_valid / halted.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [8:0] F_0  = 9'b0000_000_0_0;
    localparam logic [8:0] F_LU = 9'b1100_010_0_0;
    localparam logic [8:0] F_IW = 9'b1000_100_0_0;
    localparam logic [8:0] F_DW = 9'b1111_001_0_0;
    localparam logic [8:0] F_HL = 9'b1111_000_0_1;
    localparam logic [8:0] F_RV = 9'b0000_000_1_0;

    typedef struct {
        string       tag;
        logic [8:0]  flags;
        logic        chk_pc;
        word_t       pc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;
    exp_t        sb[$];

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk    (clk),
        .resetn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.d_srcA = R0; bus.d_srcB = R0;
        bus.d_useA = 1'b0; bus.d_useB = 1'b0;
        bus.e_dstM = R0; bus.m_dstM = R0;
        bus.d_br_taken = 1'b0; bus.d_br_target = '0;
        bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0;
        bus.m_stat_bad = 1'b0;
    endtask

    task automatic step(input string tag, input logic [8:0] ef,
                        input logic chk_pc, input word_t epc);
        exp_t e;
        logic [8:0] obs;
        sb.push_back('{tag, ef, chk_pc, epc, exp_cnt});
        #2;
        e = sb.pop_front();
        obs = {bus.f_stall, bus.d_stall, bus.e_stall, bus.m_stall,
               bus.d_bubble, bus.e_bubble, bus.w_bubble,
               bus.redir_valid, bus.halted};
        checks++;
        assert (obs === e.flags) else begin
            errors++;
            $error("FAIL %s flags obs=%b exp=%b", e.tag, obs, e.flags);
        end
        checks++;
        assert (bus.stall_cycles === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_cycles obs=%h exp=%h", e.tag,
                   bus.stall_cycles, e.cnt);
        end
        if (e.chk_pc) begin
            checks++;
            assert (bus.redir_pc === e.pc) else begin
                errors++;
                $error("FAIL %s redir_pc obs=%h exp=%h", e.tag,
                       bus.redir_pc, e.pc);
            end
        end
        if (!rstn)                 exp_cnt = '0;
        else if (ef[8] && !ef[0])  exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        @(negedge clk);

        bus.imem_busy = 1; bus.d_br_taken = 1; bus.d_br_target = 32'h55;
        step("rst_mask", F_0, 1'b0, '0);
        rstn = 1'b1; idle();
        step("post_rst", F_0, 1'b0, '0);

        bus.d_srcA = 5; bus.d_useA = 1; bus.e_dstM = 5;
        step("lu_e", F_LU, 1'b0, '0);
        bus.e_dstM = 0; bus.m_dstM = 5;
        step("lu_m", F_LU, 1'b0, '0);
        idle();
        step("lu_done", F_0, 1'b0, '0);
        bus.d_srcB = 0; bus.d_useB = 1; bus.e_dstM = 0;
        step("r0_src", F_0, 1'b0, '0);
        idle(); bus.d_srcB = 7; bus.d_useB = 1; bus.m_dstM = 7;
        step("lu_b", F_LU, 1'b0, '0);
        idle(); bus.d_srcA = 3; bus.e_dstM = 3;
        step("unused_src", F_0, 1'b0, '0);

        idle(); bus.d_srcA = 4; bus.d_useA = 1; bus.e_dstM = 4;
        bus.d_br_taken = 1; bus.d_br_target = 32'h0000_0777;
        step("br_dstall", F_LU, 1'b0, '0);
        idle();
        step("br_dstall_lost", F_0, 1'b0, '0);
        bus.d_br_taken = 1; bus.d_br_target = 32'h0000_1000;
        step("br_run", F_RV, 1'b1, 32'h0000_1000);

        idle(); bus.imem_busy = 1;
        bus.d_br_taken = 1; bus.d_br_target = 32'hBFC0_0100;
        step("iw_1", F_IW, 1'b0, '0);
        bus.d_br_target = 32'h0000_DEAD;
        step("iw_2", F_IW, 1'b0, '0);
        bus.d_br_taken = 0;
        step("iw_3", F_IW, 1'b0, '0);
        idle();
        step("iw_redir", F_RV, 1'b1, 32'hBFC0_0100);
        step("iw_clear", F_0, 1'b0, '0);

        bus.dmem_busy = 1; bus.imem_busy = 1;
        bus.d_br_taken = 1; bus.d_br_target = 32'h0000_2222;
        step("dw_1", F_DW, 1'b0, '0);
        bus.d_br_taken = 0;
        step("dw_2", F_DW, 1'b0, '0);
        bus.dmem_busy = 0;
        step("dw_to_iw", F_IW, 1'b0, '0);
        idle();
        step("dw_no_redir", F_0, 1'b0, '0);

        bus.imem_busy = 1; bus.d_br_taken = 1; bus.d_br_target = 32'h3333;
        step("pend_set", F_IW, 1'b0, '0);
        idle(); rstn = 1'b0;
        step("pend_rst", F_0, 1'b0, '0);
        rstn = 1'b1;
        step("pend_gone", F_0, 1'b0, '0);

        force dut.r_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cycles;
        exp_cnt = 32'hFFFF_FFFF;
        bus.imem_busy = 1;
        step("wrap_pre", F_IW, 1'b0, '0);
        idle();
        step("wrap_zero", F_0, 1'b0, '0);

        bus.imem_busy = 1;
        step("cnt_one", F_IW, 1'b0, '0);
        idle(); bus.m_stat_bad = 1;
        step("bad_seen", F_0, 1'b0, '0);
        idle(); bus.dmem_busy = 1; bus.d_br_taken = 1;
        bus.d_br_target = 32'h4444;
        step("halt_1", F_HL, 1'b0, '0);
        idle();
        step("halt_2", F_HL, 1'b0, '0);
        rstn = 1'b0;
        step("halt_rst", F_0, 1'b0, '0);
        rstn = 1'b1;
        step("halt_run", F_0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
